// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for the iterative InvMixColumns engine: input and output valid/ready channels.
// The mode signal exists only when MIXCOL_FWD_MODE_EN is defined.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef MIXCOL_FWD_MODE_EN
  logic         mode;

  modport master (output in_valid, in_data, out_ready, mode,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready, mode,
                  output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns on a 128-bit state, COLS_PER_CYCLE columns per clock.
// Optional MIXCOL_FWD_MODE_EN adds a mode input selecting forward MixColumns.
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  inv_mix_columns_seq_if.slave bus
);

  // Column 0 occupies the most significant 32 bits.
  typedef logic [0:3][31:0] cols_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] v);
    return xtime(xtime(xtime(v))) ^ v;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] v);
    return xtime(xtime(xtime(v))) ^ xtime(v) ^ v;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] v);
    return xtime(xtime(xtime(v))) ^ xtime(xtime(v)) ^ v;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] v);
    return xtime(xtime(xtime(v))) ^ xtime(xtime(v)) ^ xtime(v);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mule(a1) ^ mulb(a2) ^ muld(a3) ^ mul9(a0),
            mule(a2) ^ mulb(a3) ^ muld(a0) ^ mul9(a1),
            mule(a3) ^ mulb(a0) ^ muld(a1) ^ mul9(a2)};
  endfunction

`ifdef MIXCOL_FWD_MODE_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
            xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
            xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2};
  endfunction

  logic fwd_q;
`endif

  state_e       state_q;
  cols_t        work_q;
  cols_t        work_next;
  logic [1:0]   col_cnt_q;
  logic [1:0]   idx;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;

  // Only the columns addressed this cycle are rewritten; the rest pass through.
  always_comb begin
    work_next = work_q;
    idx       = '0;
    for (int unsigned i = 0; i < COLS_PER_CYCLE; i++) begin
      idx = col_cnt_q + 2'(i);
`ifdef MIXCOL_FWD_MODE_EN
      work_next[idx] = fwd_q ? fwd_col(work_q[idx]) : inv_col(work_q[idx]);
`else
      work_next[idx] = inv_col(work_q[idx]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      col_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef MIXCOL_FWD_MODE_EN
      fwd_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q     <= bus.in_data;
            col_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
`ifdef MIXCOL_FWD_MODE_EN
            fwd_q      <= bus.mode;
`endif
          end
        end
        BUSY: begin
          work_q    <= work_next;
          col_cnt_q <= col_cnt_q + STEP;
          if (col_cnt_q == LAST) begin
            out_data_q  <= work_next;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed vectors, random states against a GF(2^8) model,
// handshake timing, backpressure, reset mid-operation, and COLS_PER_CYCLE = 2/4 instances.
module tb_inv_mix_columns_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   cur_mode = 1'b0;

  always #5 clk = ~clk;

  inv_mix_columns_seq_if ifc1 ();
  inv_mix_columns_seq_if ifc2 ();
  inv_mix_columns_seq_if ifc4 ();

  // Shared stimulus for the wider-datapath instances, which run in lockstep.
  logic         v_valid = 1'b0;
  logic [127:0] v_data  = '0;
  logic         v_ready = 1'b1;

  assign ifc2.in_valid  = v_valid;
  assign ifc2.in_data   = v_data;
  assign ifc2.out_ready = v_ready;
  assign ifc4.in_valid  = v_valid;
  assign ifc4.in_data   = v_data;
  assign ifc4.out_ready = v_ready;
`ifdef MIXCOL_FWD_MODE_EN
  assign ifc2.mode = 1'b0;
  assign ifc4.mode = 1'b0;
`endif

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));

  // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input bit fwd);
    logic [7:0]  a[4];
    logic [7:0]  coef[4];
    logic [7:0]  b;
    logic [31:0] r;
    if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else     coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
    r = '0;
    for (int row = 0; row < 4; row++) begin
      b = '0;
      for (int k = 0; k < 4; k++) b = b ^ gmul(coef[k], a[(row + k) % 4]);
      r[31 - 8*row -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input bit fwd);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = ref_col(s[127 - 32*c -: 32], fwd);
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives one transaction on the 1-column instance; lat = -1 when out_valid never rises.
  task automatic run_txn(input logic [127:0] d, output logic [127:0] res, output int lat);
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = d;
`ifdef MIXCOL_FWD_MODE_EN
    ifc1.mode = cur_mode;
`endif
    @(posedge clk); #1;
    ifc1.in_valid = 1'b0;
    lat = 0;
    while (!ifc1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ifc1.out_valid) lat = -1;
    res = ifc1.out_data;
    ifc1.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ifc1.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", ifc1.in_ready);
    end
    checks++;
    if (ifc1.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", ifc1.out_valid);
    end
    checks++;
    if (ifc1.out_data !== 128'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=0", ifc1.out_data);
    end
  endtask

  task automatic test_vector_a();
    logic [127:0] res;
    int           lat;
    run_txn({4{32'h8e4da1bc}}, res, lat);
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL vec_a_latency got=%0d exp=4", lat);
    end
    checks++;
    if (res !== {4{32'hdb135345}}) begin
      failures++; $display("FAIL vec_a_data got=%h exp=%h", res, {4{32'hdb135345}});
    end
    checks++;
    if (ifc1.out_valid !== 1'b0 || ifc1.in_ready !== 1'b1) begin
      failures++; $display("FAIL vec_a_release got=%b%b exp=01", ifc1.out_valid, ifc1.in_ready);
    end
  endtask

  task automatic test_vector_b();
    logic [127:0] res;
    int           lat;
    run_txn(128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6, res, lat);
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL vec_b_latency got=%0d exp=4", lat);
    end
    checks++;
    if (res !== 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5) begin
      failures++; $display("FAIL vec_b_data got=%h exp=f20a225c01010101c6c6c6c6d4d4d4d5", res);
    end
  endtask

  task automatic test_random();
    logic [127:0] d, res, exp;
    int           lat;
    for (int n = 0; n < 20; n++) begin
      d   = rand_state();
      exp = ref_state(d, 1'b0);
      run_txn(d, res, lat);
      checks++;
      if (lat !== 4) begin
        failures++; $display("FAIL rand_latency[%0d] got=%0d exp=4", n, lat);
      end
      checks++;
      if (res !== exp) begin
        failures++; $display("FAIL rand_data[%0d] in=%h got=%h exp=%h", n, d, res, exp);
      end
    end
  endtask

  task automatic test_cols_variants();
    logic [127:0] d, exp, res2, res4;
    int           lat2, lat4;
    bit           got2, got4;
    for (int n = 0; n < 6; n++) begin
      d = (n == 0) ? 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6 : rand_state();
      exp = ref_state(d, 1'b0);
      got2 = 1'b0; got4 = 1'b0; lat2 = -1; lat4 = -1; res2 = '0; res4 = '0;
      v_valid = 1'b1;
      v_data  = d;
      @(posedge clk); #1;
      v_valid = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        @(posedge clk); #1;
        if (!got2 && ifc2.out_valid) begin got2 = 1'b1; lat2 = t; res2 = ifc2.out_data; end
        if (!got4 && ifc4.out_valid) begin got4 = 1'b1; lat4 = t; res4 = ifc4.out_data; end
      end
      checks++;
      if (lat2 !== 2) begin
        failures++; $display("FAIL cols2_latency[%0d] got=%0d exp=2", n, lat2);
      end
      checks++;
      if (res2 !== exp) begin
        failures++; $display("FAIL cols2_data[%0d] got=%h exp=%h", n, res2, exp);
      end
      checks++;
      if (lat4 !== 1) begin
        failures++; $display("FAIL cols4_latency[%0d] got=%0d exp=1", n, lat4);
      end
      checks++;
      if (res4 !== exp) begin
        failures++; $display("FAIL cols4_data[%0d] got=%h exp=%h", n, res4, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    int           t;
    d   = rand_state();
    exp = ref_state(d, 1'b0);
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = d;
    @(posedge clk); #1;
    ifc1.in_valid = 1'b0;
    t = 0;
    while (!ifc1.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (ifc1.out_data !== exp) begin
      failures++; $display("FAIL stall_first_data got=%h exp=%h", ifc1.out_data, exp);
    end
    for (int c = 0; c < 10; c++) begin
      ifc1.in_valid = 1'b1;
      ifc1.in_data  = ~d;
      @(posedge clk); #1;
      checks++;
      if (ifc1.out_valid !== 1'b1) begin
        failures++; $display("FAIL stall_out_valid[%0d] got=%b exp=1", c, ifc1.out_valid);
      end
      checks++;
      if (ifc1.out_data !== exp) begin
        failures++; $display("FAIL stall_out_data[%0d] got=%h exp=%h", c, ifc1.out_data, exp);
      end
      checks++;
      if (ifc1.in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, ifc1.in_ready);
      end
    end
    ifc1.in_valid  = 1'b0;
    ifc1.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.out_ready = 1'b0;
    checks++;
    if (ifc1.out_valid !== 1'b0 || ifc1.in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%b%b exp=01", ifc1.out_valid, ifc1.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d[2], exp[2], res[2];
    int           acc_cyc[2];
    int           nacc, nres, cyc;
    bit           acc, fire;
    for (int i = 0; i < 2; i++) begin
      d[i]   = rand_state();
      exp[i] = ref_state(d[i], 1'b0);
      res[i] = '0;
      acc_cyc[i] = 0;
    end
    nacc = 0; nres = 0; cyc = 0;
    ifc1.out_ready = 1'b1;
    ifc1.in_valid  = 1'b1;
    ifc1.in_data   = d[0];
    while ((nacc < 2 || nres < 2) && cyc < 60) begin
      acc  = ifc1.in_valid && ifc1.in_ready;
      fire = ifc1.out_valid && ifc1.out_ready;
      if (fire && nres < 2) begin res[nres] = ifc1.out_data; nres++; end
      @(posedge clk); #1;
      cyc++;
      if (acc && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 2) ifc1.in_data = d[nacc];
        else          ifc1.in_valid = 1'b0;
      end
    end
    ifc1.in_valid  = 1'b0;
    ifc1.out_ready = 1'b0;
    checks++;
    if (nacc !== 2 || nres !== 2) begin
      failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", nacc, nres);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 6) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=6", acc_cyc[1] - acc_cyc[0]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (res[i] !== exp[i]) begin
        failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, res[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res;
    int           lat;
    ifc1.in_valid = 1'b1;
    ifc1.in_data  = rand_state();
    @(posedge clk); #1;
    ifc1.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ifc1.out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_out_valid got=%b exp=0", ifc1.out_valid);
    end
    checks++;
    if (ifc1.out_data !== 128'h0) begin
      failures++; $display("FAIL midrst_out_data got=%h exp=0", ifc1.out_data);
    end
    checks++;
    if (ifc1.in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_in_ready got=%b exp=1", ifc1.in_ready);
    end
    run_txn({4{32'h8e4da1bc}}, res, lat);
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL midrst_latency got=%0d exp=4", lat);
    end
    checks++;
    if (res !== {4{32'hdb135345}}) begin
      failures++; $display("FAIL midrst_data got=%h exp=%h", res, {4{32'hdb135345}});
    end
  endtask

`ifdef MIXCOL_FWD_MODE_EN
  task automatic test_fwd_mode();
    logic [127:0] d, res, exp;
    int           lat;
    cur_mode = 1'b1;
    run_txn({2{32'hdb135345, 32'h2d26314c}}, res, lat);
    checks++;
    if (res !== {2{32'h8e4da1bc, 32'h4d7ebdf8}}) begin
      failures++; $display("FAIL fwd_vec_data got=%h exp=%h", res, {2{32'h8e4da1bc, 32'h4d7ebdf8}});
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL fwd_vec_latency got=%0d exp=4", lat);
    end
    for (int n = 0; n < 8; n++) begin
      cur_mode = n[0];
      d   = rand_state();
      exp = ref_state(d, cur_mode);
      ifc1.in_valid = 1'b1;
      ifc1.in_data  = d;
      ifc1.mode     = cur_mode;
      @(posedge clk); #1;
      ifc1.in_valid = 1'b0;
      lat = 0;
      while (!ifc1.out_valid && lat < 20) begin
        ifc1.mode = ~ifc1.mode;
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (ifc1.out_data !== exp) begin
        failures++; $display("FAIL fwd_toggle_data[%0d] mode=%b got=%h exp=%h", n, cur_mode, ifc1.out_data, exp);
      end
      ifc1.out_ready = 1'b1;
      @(posedge clk); #1;
      ifc1.out_ready = 1'b0;
    end
    cur_mode = 1'b0;
    ifc1.mode = 1'b0;
  endtask
`endif

  initial begin
    ifc1.in_valid  = 1'b0;
    ifc1.in_data   = '0;
    ifc1.out_ready = 1'b0;
`ifdef MIXCOL_FWD_MODE_EN
    ifc1.mode = 1'b0;
`endif
    test_reset();
    test_vector_a();
    test_vector_b();
    test_random();
    test_cols_variants();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef MIXCOL_FWD_MODE_EN
    test_fwd_mode();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
